// File: rtl/cordic_pkg.sv
// Shared constants and clamp helper for the CORDIC output-stage octant mapper.
package cordic_pkg;

  localparam logic [1:0] Q_PP = 2'b00;
  localparam logic [1:0] Q_NP = 2'b01;
  localparam logic [1:0] Q_NN = 2'b10;
  localparam logic [1:0] Q_PN = 2'b11;

  localparam int OCT_SWAP_BIT = 2;

  localparam int W_DEF      = 13;
  localparam int OFFSET_DEF = 1 << (W_DEF - 2);

  // Clamp v into [lo, hi]; callers detect clamping by comparing result with v.
  function automatic logic signed [31:0] sat_w(
    input logic signed [31:0] v,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi
  );
    logic signed [31:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_sat.sv
// Combinational (W+2)-bit to W-bit clamp: unsigned range in offset mode,
// signed range in two's complement mode, with an overflow flag.
module cordic_sat
  import cordic_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic signed [W+1:0] i_v,
  input  logic                i_signed_mode,
  output logic        [W-1:0] o_q,
  output logic                o_ovf
);

  localparam logic signed [31:0] S_LO = -(32'sd1 <<< (W - 1));
  localparam logic signed [31:0] S_HI = (32'sd1 <<< (W - 1)) - 32'sd1;
  localparam logic signed [31:0] U_HI = (32'sd1 <<< W) - 32'sd1;

  logic signed [31:0] w_v;
  logic signed [31:0] w_lo;
  logic signed [31:0] w_hi;
  logic signed [31:0] w_c;

  always_comb begin
    w_v = {{(32 - W - 2){i_v[W+1]}}, i_v};
    if (i_signed_mode) begin
      w_lo = S_LO;
      w_hi = S_HI;
    end else begin
      w_lo = 32'sd0;
      w_hi = U_HI;
    end
    w_c   = sat_w(w_v, w_lo, w_hi);
    o_q   = w_c[W-1:0];
    o_ovf = (w_c != w_v);
  end

endmodule

// File: rtl/cordic_octant_map.sv
// Output-stage octant mapper: swap/fold first-octant X/Y, then offset and
// saturate, through a two-stage valid/ready pipeline carrying a sideband tag.
module cordic_octant_map
  import cordic_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int OFFSET = 1 << (W - 2),
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     xi,
  input  logic [W-1:0]     yi,
  input  logic [2:0]       octant,
  input  logic             signed_out,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     xo,
  output logic [W-1:0]     yo,
  output logic             sat,
  output logic [TAG_W-1:0] tag_out,
  output logic [15:0]      sat_count
);

  localparam logic [W+1:0] OFF_V = OFFSET[W+1:0];

  logic               r_s1_valid;
  logic signed [W:0]  r_s1_x;
  logic signed [W:0]  r_s1_y;
  logic               r_s1_mode;
  logic [TAG_W-1:0]   r_s1_tag;

  logic               r_s2_valid;
  logic [W-1:0]       r_xo;
  logic [W-1:0]       r_yo;
  logic               r_sat;
  logic [TAG_W-1:0]   r_tag;
  logic [15:0]        r_sat_cnt;

  logic               w_s2_en;
  logic               w_s1_en;
  logic [W-1:0]       w_xp;
  logic [W-1:0]       w_yp;
  logic signed [W:0]  w_xs;
  logic signed [W:0]  w_ys;
  logic signed [W:0]  w_xf;
  logic signed [W:0]  w_yf;
  logic [W+1:0]       w_off;
  logic signed [W+1:0] w_xv;
  logic signed [W+1:0] w_yv;
  logic [W-1:0]       w_xq;
  logic [W-1:0]       w_yq;
  logic               w_xovf;
  logic               w_yovf;

  assign w_s2_en = !r_s2_valid || out_ready;
  assign w_s1_en = !r_s1_valid || w_s2_en;
  // Registers are cleared during rst, so the block can always advertise room.
  assign in_ready = w_s1_en || rst;

  // Stage-1 datapath: optional X/Y exchange, then quarter sign folding in W+1 bits.
  always_comb begin
    if (octant[OCT_SWAP_BIT]) begin
      w_xp = yi;
      w_yp = xi;
    end else begin
      w_xp = xi;
      w_yp = yi;
    end
    w_xs = {w_xp[W-1], w_xp};
    w_ys = {w_yp[W-1], w_yp};
    case (octant[1:0])
      Q_PP: begin
        w_xf = w_xs;
        w_yf = w_ys;
      end
      Q_NP: begin
        w_xf = -w_xs;
        w_yf = w_ys;
      end
      Q_NN: begin
        w_xf = -w_xs;
        w_yf = -w_ys;
      end
      Q_PN: begin
        w_xf = w_xs;
        w_yf = -w_ys;
      end
      default: begin
        w_xf = w_xs;
        w_yf = w_ys;
      end
    endcase
  end

  // Stage-2 datapath: offset-binary bias in W+2 bits ahead of the clamps.
  always_comb begin
    if (r_s1_mode) begin
      w_off = '0;
    end else begin
      w_off = OFF_V;
    end
    w_xv = {r_s1_x[W], r_s1_x} + w_off;
    w_yv = {r_s1_y[W], r_s1_y} + w_off;
  end

  cordic_sat #(.W(W)) u_sat_x (
    .i_v           (w_xv),
    .i_signed_mode (r_s1_mode),
    .o_q           (w_xq),
    .o_ovf         (w_xovf)
  );

  cordic_sat #(.W(W)) u_sat_y (
    .i_v           (w_yv),
    .i_signed_mode (r_s1_mode),
    .o_q           (w_yq),
    .o_ovf         (w_yovf)
  );

  // Stage-1 register: folded beat, its mode and tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_mode  <= 1'b0;
      r_s1_tag   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_x    <= w_xf;
        r_s1_y    <= w_yf;
        r_s1_mode <= signed_out;
        r_s1_tag  <= tag_in;
      end else begin
        r_s1_x    <= r_s1_x;
        r_s1_y    <= r_s1_y;
        r_s1_mode <= r_s1_mode;
        r_s1_tag  <= r_s1_tag;
      end
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Stage-2 register: holds outputs stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_xo       <= '0;
      r_yo       <= '0;
      r_sat      <= 1'b0;
      r_tag      <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_xo  <= w_xq;
        r_yo  <= w_yq;
        r_sat <= w_xovf || w_yovf;
        r_tag <= r_s1_tag;
      end else begin
        r_xo  <= r_xo;
        r_yo  <= r_yo;
        r_sat <= r_sat;
        r_tag <= r_tag;
      end
    end else begin
      r_s2_valid <= r_s2_valid;
    end
  end

  // Saturated-beat counter, counting only delivered beats and sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_cnt <= 16'h0000;
    end else if (r_s2_valid && out_ready && r_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'h0001;
    end else begin
      r_sat_cnt <= r_sat_cnt;
    end
  end

  assign out_valid = r_s2_valid;
  assign xo        = r_xo;
  assign yo        = r_yo;
  assign sat       = r_sat;
  assign tag_out   = r_tag;
  assign sat_count = r_sat_cnt;

endmodule

// File: tb/tb_cordic_octant_map.sv
// Scoreboard bench for cordic_octant_map at W=13: a reference model predicts each
// accepted beat, and outputs are compared every cycle they are valid.
module tb_cordic_octant_map;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] xi;
  logic [12:0] yi;
  logic [2:0]  octant;
  logic        signed_out;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] xo;
  logic [12:0] yo;
  logic        sat;
  logic [3:0]  tag_out;
  logic [15:0] sat_count;

  typedef struct {
    logic [12:0] x;
    logic [12:0] y;
    logic        s;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_n   = 0;
  int   exp_cnt  = 0;
  bit   chk_lat  = 1'b0;

  cordic_octant_map #(.W(13), .OFFSET(2048), .TAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .xi         (xi),
    .yi         (yi),
    .octant     (octant),
    .signed_out (signed_out),
    .tag_in     (tag_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xo         (xo),
    .yo         (yo),
    .sat        (sat),
    .tag_out    (tag_out),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (step %0d)", tag, got, exp, step_n);
    end
  endtask

  function automatic exp_t model(input logic [12:0] xin, input logic [12:0] yin,
                                 input logic [2:0] oc, input logic m, input logic [3:0] tg);
    exp_t e;
    int a, b, t, lo, hi;
    logic [31:0] ua, ub;
    logic sx, sy;
    a = int'($signed(xin));
    b = int'($signed(yin));
    if (oc[2]) begin
      t = a; a = b; b = t;
    end
    if (oc[1:0] == 2'b01 || oc[1:0] == 2'b10) a = -a;
    if (oc[1]) b = -b;
    if (!m) begin
      a = a + 2048; b = b + 2048; lo = 0; hi = 8191;
    end else begin
      lo = -4096; hi = 4095;
    end
    sx = (a < lo) || (a > hi);
    sy = (b < lo) || (b > hi);
    if (a < lo) a = lo;
    if (a > hi) a = hi;
    if (b < lo) b = lo;
    if (b > hi) b = hi;
    ua = a;
    ub = b;
    e.x = ua[12:0];
    e.y = ub[12:0];
    e.s = sx | sy;
    e.tag = tg;
    e.acc = 0;
    return e;
  endfunction

  // One cycle: drive at negedge, observe/score, report whether the beat was accepted.
  task automatic step(input logic v, input logic [12:0] x_, input logic [12:0] y_,
                      input logic [2:0] oc, input logic m, input logic [3:0] tg,
                      input logic ordy, output logic acc);
    exp_t e;
    logic exp_rdy;
    @(negedge clk);
    in_valid = v; xi = x_; yi = y_; octant = oc; signed_out = m; tag_in = tg;
    out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("sat_count", sat_count, exp_cnt);
    if (out_valid) begin
      if (q.size() == 0) begin
        check_eq("spurious_out_valid", out_valid, 1'b0);
      end else begin
        check_eq("xo", xo, q[0].x);
        check_eq("yo", yo, q[0].y);
        check_eq("sat", sat, q[0].s);
        check_eq("tag_out", tag_out, q[0].tag);
        if (ordy) begin
          if (chk_lat) check_eq("latency", step_n - q[0].acc, 2);
          if (q[0].s && exp_cnt < 65535) exp_cnt++;
          void'(q.pop_front());
        end
      end
    end
    acc = v && in_ready;
    if (acc) begin
      e = model(x_, y_, oc, m, tg);
      e.acc = step_n;
      q.push_back(e);
    end
    step_n++;
  endtask

  task automatic send(input logic [12:0] x_, input logic [12:0] y_, input logic [2:0] oc,
                      input logic m, input logic [3:0] tg, input bit rand_rdy);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      step(1'b1, x_, y_, oc, m, tg, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      n++;
    end
    if (!acc) check_eq("send_timeout", n, 0);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 13'h0, 13'h0, 3'd0, 1'b0, 4'h0, 1'b1, acc);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check_eq("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check_eq("in_ready_in_reset", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    q.delete();
    exp_cnt = 0;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_sat_count", sat_count, 16'h0);
  endtask

  initial begin
    logic acc;
    rst = 1'b1; in_valid = 1'b0; xi = '0; yi = '0; octant = '0;
    signed_out = 1'b0; tag_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();
    check_eq("rst_xo", xo, 13'h0);
    check_eq("rst_yo", yo, 13'h0);
    check_eq("rst_sat", sat, 1'b0);
    check_eq("rst_tag", tag_out, 4'h0);

    // Directed beats, no stalls: latency checked on each delivery.
    chk_lat = 1'b1;
    send(13'h0100, 13'h0200, 3'd0, 1'b0, 4'h1, 1'b0); idle(3);
    send(13'h0100, 13'h0200, 3'd5, 1'b0, 4'h2, 1'b0); idle(3);
    send(13'h1000, 13'h0000, 3'd0, 1'b0, 4'h3, 1'b0); idle(3);
    send(13'h1000, 13'h0000, 3'd1, 1'b1, 4'h4, 1'b0); idle(3);
    send(13'h0123, 13'h1F00, 3'd2, 1'b1, 4'h5, 1'b0); idle(3);
    send(13'h0FFF, 13'h1000, 3'd3, 1'b0, 4'h6, 1'b0); idle(3);
    send(13'h0ABC, 13'h0456, 3'd6, 1'b0, 4'h7, 1'b0); idle(3);
    send(13'h1000, 13'h0FFF, 3'd7, 1'b1, 4'h8, 1'b0); idle(3);
    // Back-to-back at full throughput.
    for (int i = 0; i < 6; i++)
      send(13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)), 3'(i), 1'(i % 2), 4'(i), 1'b0);
    drain();

    // Eight tagged beats against random downstream stalls.
    chk_lat = 1'b0;
    for (int i = 0; i < 8; i++)
      send(13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'(4'hA + i), 1'b1);
    for (int i = 0; i < 20; i++)
      step(1'b0, 13'h0, 13'h0, 3'd0, 1'b0, 4'h0, 1'($urandom_range(0, 1)), acc);
    drain();

    // Reset with two beats in flight, then a fresh beat after release.
    step(1'b1, 13'h1000, 13'h0000, 3'd0, 1'b0, 4'hC, 1'b0, acc);
    step(1'b1, 13'h0200, 13'h0100, 3'd4, 1'b0, 4'hD, 1'b0, acc);
    do_reset();
    chk_lat = 1'b1;
    send(13'h0100, 13'h0200, 3'd0, 1'b0, 4'hE, 1'b0);
    idle(1);
    check_eq("post_rst_not_early", out_valid, 1'b0);
    idle(1);
    check_eq("post_rst_delivered", q.size(), 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
